alu_seq_unit: RTL and testbench

Parametrised, handshaked successor to the team's 8-bit combinational ALU decoder.
- Operands are accepted over a valid/ready interface; one registered result is returned over a second valid/ready interface.
- Multiplication is iterative shift-add, one bit per cycle. All other ops complete in one cycle.
- Operation is either selected explicitly per transaction, or auto-cycled by an internal counter in decoder-compatible mode.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_seq_mul.sv | 57 +++++
 rtl/alu_seq_unit.sv | 140 ++++++++++++++
 tb/tb_alu_seq_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared op codes and FSM state encoding for the sequential ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_MUL  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_LAND = 3'd3;
  localparam logic [2:0] OP_ADD  = 3'd4;
  localparam logic [2:0] OP_SUB  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// done is asserted during the last step; product then already includes that
// step so the caller can register it on the same edge.
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = $clog2(WIDTH);

  logic               running;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_step;

  // Accumulator value after the current step's conditional add.
  always_comb begin
    acc_step = acc;
    if (mplier[0]) acc_step = acc + mcand;
  end

  assign done    = running && (cnt == CW'(WIDTH - 1));
  assign product = acc_step;

  // Operand load on start, then one add/shift per cycle until done.
  always_ff @(posedge clk) begin
    if (rst) begin
      running <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
      mcand   <= {{WIDTH{1'b0}}, a};
      mplier  <= b;
    end else if (running) begin
      acc    <= acc_step;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) running <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// Handshaked sequential ALU: single-cycle logic/arith ops, iterative MUL,
// optional auto-cycling op counter for decoder-compatible operation.
module alu_seq_unit
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AUTO_OPS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       op,
  input  logic             auto_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             illegal,
  output logic [2:0]       op_out
);

  state_t             state, state_nxt;
  logic [1:0]         op_ctr;
  logic [2:0]         eff_op;
  logic               accept;
  logic               load_alu;
  logic               mul_start;
  logic               mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   alu_hi;
  logic               alu_ill;

  assign eff_op    = auto_mode ? {1'b0, op_ctr} : op;
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && (eff_op == OP_MUL);
  assign load_alu  = accept && (eff_op != OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (in_a),
    .b       (in_b),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Single-cycle datapath for every op except MUL.
  always_comb begin
    alu_res = '0;
    alu_hi  = '0;
    alu_ill = 1'b0;
    sum     = {1'b0, in_a} + {1'b0, in_b};
    diff    = {1'b0, in_a} - {1'b0, in_b};
    case (eff_op)
      OP_OR:   alu_res = in_a | in_b;
      OP_AND:  alu_res = in_a & in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_LAND: alu_res[0] = (in_a != '0) && (in_b != '0);
      OP_ADD: begin
        alu_res   = sum[WIDTH-1:0];
        alu_hi[0] = sum[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff[WIDTH-1:0];
        alu_hi[0] = diff[WIDTH];
      end
      OP_ILL:  alu_ill = 1'b1;
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (eff_op == OP_MUL) ? ST_BUSY : ST_HOLD;
      end
      ST_BUSY: begin
        if (mul_done) state_nxt = ST_HOLD;
      end
      ST_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Result registers: loaded at accept for single-cycle ops, at the last MUL step.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      illegal   <= 1'b0;
      op_out    <= '0;
    end else if (load_alu) begin
      result    <= alu_res;
      result_hi <= alu_hi;
      zero      <= (alu_res == '0) && (alu_hi == '0);
      illegal   <= alu_ill;
      op_out    <= eff_op;
    end else if (mul_done) begin
      result    <= mul_prod[WIDTH-1:0];
      result_hi <= mul_prod[2*WIDTH-1:WIDTH];
      zero      <= (mul_prod == '0);
      illegal   <= 1'b0;
      op_out    <= OP_MUL;
    end
  end

  // Auto-mode op counter, advances only on accepted auto transactions.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_ctr <= '0;
    end else if (accept && auto_mode) begin
      if (op_ctr == 2'(AUTO_OPS - 1)) op_ctr <= '0;
      else                            op_ctr <= op_ctr + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: transaction-level reference model,
// per-cycle compare process, directed scenarios and a randomized phase.
`timescale 1ns/1ps
module tb_alu_seq_unit;

  localparam int W  = 8;
  localparam int AO = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a, in_b;
  logic [2:0]   op;
  logic         auto_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result, result_hi;
  logic         zero, illegal;
  logic [2:0]   op_out;

  logic rand_phase = 1'b0;
  logic or_dir     = 1'b1;
  logic or_rand    = 1'b1;
  assign out_ready = rand_phase ? or_rand : or_dir;

  alu_seq_unit #(.WIDTH(W), .AUTO_OPS(AO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .op(op), .auto_mode(auto_mode),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .zero(zero), .illegal(illegal), .op_out(op_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input bit ok, input string name, input string detail);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  typedef struct {
    int unsigned res;
    int unsigned hi;
    bit          z;
    bit          ill;
    int unsigned opx;
    int unsigned due;
  } txn_t;

  // Transaction-level reference: plain integer arithmetic on the op rules.
  function automatic txn_t model(int unsigned a, int unsigned b, int unsigned opx);
    txn_t t;
    longint unsigned full = 64'd1 << W;
    longint unsigned p;
    t = '{0, 0, 1'b0, 1'b0, opx, 0};
    case (opx)
      0: begin p = longint'(a) * longint'(b); t.res = int'(p % full); t.hi = int'(p / full); end
      1: t.res = a | b;
      2: t.res = a & b;
      3: t.res = (a != 0 && b != 0) ? 1 : 0;
      4: begin p = longint'(a) + longint'(b); t.res = int'(p % full); t.hi = int'(p / full); end
      5: begin t.res = int'((longint'(a) + full - longint'(b)) % full); t.hi = (a < b) ? 1 : 0; end
      6: t.res = a ^ b;
      default: t.ill = 1'b1;
    endcase
    t.z = (t.res == 0 && t.hi == 0);
    return t;
  endfunction

  txn_t        q[$];
  txn_t        got[$];
  int unsigned ctr = 0;
  int unsigned cyc = 0;
  bit          rst_d = 1'b0;
  bit          started = 1'b0;

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge clk) begin
    bit   exp_v;
    txn_t e, a;
    cyc++;
    exp_v = (q.size() > 0) && (cyc >= q[0].due);
    if (rst_d) begin
      started = 1'b1;
      chk(out_valid === 1'b0 && in_ready === 1'b1 && result === '0 && result_hi === '0 &&
          zero === 1'b0 && illegal === 1'b0 && op_out === 3'd0, "reset_state",
          $sformatf("got v=%b rdy=%b res=%h hi=%h z=%b il=%b op=%0d, want v=0 rdy=1 others 0",
                    out_valid, in_ready, result, result_hi, zero, illegal, op_out));
    end else if (started) begin
      chk(in_ready === (q.size() == 0), "in_ready",
          $sformatf("cyc %0d got %b want %b", cyc, in_ready, q.size() == 0));
      chk(out_valid === exp_v, "out_valid",
          $sformatf("cyc %0d got %b want %b", cyc, out_valid, exp_v));
      if (exp_v) begin
        e = q[0];
        chk(result === W'(e.res) && result_hi === W'(e.hi) && zero === e.z &&
            illegal === e.ill && op_out === 3'(e.opx), "result",
            $sformatf("cyc %0d got res=%h hi=%h z=%b il=%b op=%0d want res=%h hi=%h z=%b il=%b op=%0d",
                      cyc, result, result_hi, zero, illegal, op_out,
                      W'(e.res), W'(e.hi), e.z, e.ill, e.opx));
      end
    end
    if (rst) begin
      q.delete();
      ctr = 0;
    end else if (started) begin
      if (exp_v && out_ready === 1'b1) begin
        a = '{int'(result), int'(result_hi), zero, illegal, int'(op_out), cyc};
        got.push_back(a);
        void'(q.pop_front());
      end else if (q.size() == 0 && in_valid === 1'b1) begin
        int unsigned eop;
        eop = auto_mode ? ctr : int'(op);
        if (auto_mode) ctr = (ctr + 1) % AO;
        e = model(int'(in_a), int'(in_b), eop);
        e.due = cyc + ((eop == 0) ? W + 1 : 1);
        q.push_back(e);
      end
    end
    rst_d = rst;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a transaction and hold it until accepted; returns just after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2:0] o, input logic am);
    int n = 0;
    in_valid = 1'b1; in_a = a; in_b = b; op = o; auto_mode = am;
    forever begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
      if (++n > 100) begin
        chk(1'b0, "accept_timeout", "in_ready never rose within 100 cycles, want 1");
        break;
      end
    end
    step();
    in_valid = 1'b0;
    in_a = W'($urandom); in_b = W'($urandom); op = 3'($urandom); auto_mode = 1'($urandom);
  endtask

  // Wait for out_valid; lat = falling edges since the accept edge.
  task automatic wait_out(output int lat);
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
      if (lat > 100) begin
        chk(1'b0, "out_timeout", "out_valid never rose within 100 cycles, want 1");
        break;
      end
    end
  endtask

  task automatic chk_out(input string name, input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic z, input logic il, input logic [2:0] o);
    chk(result === r && result_hi === h && zero === z && illegal === il && op_out === o, name,
        $sformatf("got res=%h hi=%h z=%b il=%b op=%0d want res=%h hi=%h z=%b il=%b op=%0d",
                  result, result_hi, zero, illegal, op_out, r, h, z, il, o));
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    int   lat;
    txn_t m;
    int   exp_op[5]  = '{0, 1, 2, 3, 0};
    int   exp_res[5] = '{18, 7, 2, 1, 18};

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; op = '0; auto_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    m = model(200, 150, 0);
    chk(m.res == 'h30 && m.hi == 'h75 && !m.z, "model_mul", $sformatf("got %h/%h want 30/75", m.res, m.hi));
    m = model(3, 5, 5);
    chk(m.res == 'hFE && m.hi == 1, "model_sub", $sformatf("got %h/%h want fe/1", m.res, m.hi));
    m = model(0, 9, 3);
    chk(m.res == 0 && m.z, "model_land", $sformatf("got %h z=%b want 0 z=1", m.res, m.z));

    // MUL latency and value
    send(8'd200, 8'd150, 3'd0, 1'b0);
    wait_out(lat);
    chk(lat == W + 1, "mul_latency", $sformatf("got %0d want %0d", lat, W + 1));
    chk_out("mul_200x150", 8'h30, 8'h75, 1'b0, 1'b0, 3'd0);
    step();

    // ADD carry and SUB borrow
    send(8'hFF, 8'h01, 3'd4, 1'b0);
    wait_out(lat);
    chk(lat == 1, "add_latency", $sformatf("got %0d want 1", lat));
    chk_out("add_carry", 8'h00, 8'h01, 1'b0, 1'b0, 3'd4);
    step();
    send(8'd3, 8'd5, 3'd5, 1'b0);
    wait_out(lat);
    chk_out("sub_borrow", 8'hFE, 8'h01, 1'b0, 1'b0, 3'd5);
    step();

    // Auto mode, back to back
    for (int i = 0; i < 5; i++) send(8'd6, 8'd3, 3'd7, 1'b1);
    wait_out(lat);
    step();
    chk(got.size() >= 5, "auto_count", $sformatf("got %0d results want >=5", got.size()));
    if (got.size() >= 5)
      for (int i = 0; i < 5; i++) begin
        m = got[got.size() - 5 + i];
        chk(m.opx == exp_op[i] && m.res == exp_res[i], "auto_seq",
            $sformatf("idx %0d got op=%0d res=%0d want op=%0d res=%0d", i, m.opx, m.res, exp_op[i], exp_res[i]));
      end

    // Back-pressure: result held, input ignored
    or_dir = 1'b0;
    send(8'h3C, 8'h81, 3'd1, 1'b0);
    wait_out(lat);
    step();
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in_a = W'($urandom); in_b = W'($urandom); op = 3'($urandom);
      @(negedge clk);
      chk(out_valid === 1'b1 && in_ready === 1'b0 && result === 8'hBD, "hold_stable",
          $sformatf("got v=%b rdy=%b res=%h want v=1 rdy=0 res=bd", out_valid, in_ready, result));
      step();
    end
    in_valid = 1'b0; or_dir = 1'b1;
    step();
    @(negedge clk);
    chk(in_ready === 1'b1 && out_valid === 1'b0, "hold_release",
        $sformatf("got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid));
    step();

    // Reset in BUSY cycle 4 (op counter is 1 here)
    send(8'd200, 8'd150, 3'd0, 1'b0);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk(out_valid === 1'b0 && in_ready === 1'b1, "abort_state",
        $sformatf("got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready));
    step();
    send(8'h0F, 8'hF0, 3'd1, 1'b0);
    wait_out(lat);
    chk_out("or_after_abort", 8'hFF, 8'h00, 1'b0, 1'b0, 3'd1);
    step();
    send(8'd3, 8'd4, 3'd5, 1'b1);
    wait_out(lat);
    chk_out("ctr_cleared", 8'd12, 8'h00, 1'b0, 1'b0, 3'd0);
    step();

    // Illegal op and LAND zero
    send(8'h55, 8'hAA, 3'd7, 1'b0);
    wait_out(lat);
    chk_out("illegal_op", 8'h00, 8'h00, 1'b1, 1'b1, 3'd7);
    step();
    send(8'd0, 8'd9, 3'd3, 1'b0);
    wait_out(lat);
    chk_out("land_zero", 8'h00, 8'h00, 1'b1, 1'b0, 3'd3);
    step();
    send(8'hFF, 8'hFF, 3'd0, 1'b0);
    wait_out(lat);
    chk_out("mul_max", 8'h01, 8'hFE, 1'b0, 1'b0, 3'd0);
    step();

    // Randomized phase with random back-pressure
    rand_phase = 1'b1;
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) step();
      send(pick(), pick(), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 3) == 0));
    end
    for (int i = 0; i < 200 && q.size() > 0; i++) step();
    chk(q.size() == 0, "drain", $sformatf("got %0d outstanding want 0", q.size()));
    rand_phase = 1'b0;
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  always @(posedge clk) begin
    #1 or_rand = ($urandom_range(0, 3) != 0);
  end

endmodule
